// File: rtl/i2s_receive_tdm.sv
// i2s_receive_tdm
//   I2S / left-justified / TDM serial audio receiver that runs entirely in the
//   system clock domain. BCLK, WS and SD are oversampled. The bit stream is
//   framed into CHANNELS slots of SLOT_W bits, and the top DATA_W bits of each
//   slot (MSB first) are kept. A complete set of channel words is published
//   once per good frame.
// Ports
//   clk        system clock (> 4x BCLK)
//   rst        synchronous active-high reset
//   bclk/ws/sd asynchronous serial audio inputs
//   data       channel words, channel n at [n*DATA_W +: DATA_W]
//   valid      one-cycle pulse, data updated in the same cycle
//   frame_err  one-cycle pulse, the frame that just ended had the wrong length
//   locked     high after an error-free frame, cleared by reset or frame_err
module i2s_receive_tdm #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SLOT_W      = 32,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bclk,
  input  logic                         ws,
  input  logic                         sd,
  output logic [DATA_W*CHANNELS-1:0]   data,
  output logic                         valid,
  output logic                         frame_err,
  output logic                         locked
);

  localparam int unsigned FRAME_BITS = SLOT_W * CHANNELS;
  localparam int unsigned CNT_MAX    = FRAME_BITS + 1;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   evt_q, evt_d;
  logic                   ws_smp_q, ws_smp_d;
  logic                   sd_smp_q, sd_smp_d;
  logic                   ws_last_q, ws_last_d;
  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W*CHANNELS-1:0] stage_q, stage_d;
  logic [DATA_W*CHANNELS-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   locked_q, locked_d;

  logic                   boundary;
  logic                   do_shift;
  logic                   do_check;
  logic [CNT_W-1:0]       bit_idx;
  logic [CNT_W-1:0]       chk_cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       slot;
  logic [CNT_W-1:0]       pos;
  logic [DATA_W-1:0]      shift_nxt;

  // Synchronisers. The bit event and its ws/sd samples are registered once
  // more, so that every frame decision is taken from flopped values only.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk};
    ws_sync_d   = {ws_sync_q[SYNC_STAGES-2:0], ws};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sd};
    bclk_prev_d = bclk_sync_q[SYNC_STAGES-1];
    evt_d       = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
    ws_smp_d    = ws_sync_q[SYNC_STAGES-1];
    sd_smp_d    = sd_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    stage_d   = stage_q;
    ws_last_d = ws_last_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    locked_d  = locked_q;
    do_shift  = 1'b0;
    do_check  = 1'b0;
    bit_idx   = bitcnt_q;
    chk_cnt   = bitcnt_q;
    cnt_inc   = (bitcnt_q == CNT_W'(CNT_MAX)) ? bitcnt_q : bitcnt_q + CNT_W'(1);
    boundary  = (MODE == 0) ? (ws_last_q & ~ws_smp_q) : (~ws_last_q & ws_smp_q);

    if (evt_q) begin
      ws_last_d = ws_smp_q;
      if (state_q == ST_IDLE) begin
        // First boundary only opens a frame; no check is made on it.
        if (boundary) begin
          state_d = ST_RUN;
          if (MODE == 0) begin
            bitcnt_d = '0;
          end else begin
            do_shift = 1'b1;
            bit_idx  = '0;
            bitcnt_d = CNT_W'(1);
          end
        end
      end else if (MODE == 0) begin
        // Boundary bit is the last bit of the ending frame.
        do_shift = 1'b1;
        bit_idx  = bitcnt_q;
        if (boundary) begin
          do_check = 1'b1;
          chk_cnt  = cnt_inc;
          bitcnt_d = '0;
        end else begin
          bitcnt_d = cnt_inc;
        end
      end else begin
        // Boundary bit closes the old frame, then is bit 0 of the new one.
        do_shift = 1'b1;
        if (boundary) begin
          do_check = 1'b1;
          chk_cnt  = bitcnt_q;
          bit_idx  = '0;
          bitcnt_d = CNT_W'(1);
        end else begin
          bit_idx  = bitcnt_q;
          bitcnt_d = cnt_inc;
        end
      end
    end

    slot      = bit_idx / CNT_W'(SLOT_W);
    pos       = bit_idx % CNT_W'(SLOT_W);
    shift_nxt = (shift_q << 1) | DATA_W'(sd_smp_q);

    if (do_shift && (pos < CNT_W'(DATA_W))) begin
      shift_d = shift_nxt;
      if (pos == CNT_W'(DATA_W - 1)) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (slot == CNT_W'(c)) stage_d[c*DATA_W +: DATA_W] = shift_nxt;
        end
      end
    end

    if (do_check) begin
      if (chk_cnt == CNT_W'(FRAME_BITS)) begin
        // In MODE 0 the closing bit may complete the last word, so publish
        // the updated staging; in MODE 1 the current bit belongs to the next
        // frame and must not be included.
        data_d   = (MODE == 0) ? stage_d : stage_q;
        valid_d  = 1'b1;
        locked_d = 1'b1;
      end else begin
        ferr_d   = 1'b1;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync_q <= '0;
      ws_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
      evt_q       <= 1'b0;
      ws_smp_q    <= 1'b0;
      sd_smp_q    <= 1'b0;
      ws_last_q   <= 1'b0;
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      stage_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      ws_sync_q   <= ws_sync_d;
      sd_sync_q   <= sd_sync_d;
      bclk_prev_q <= bclk_prev_d;
      evt_q       <= evt_d;
      ws_smp_q    <= ws_smp_d;
      sd_smp_q    <= sd_smp_d;
      ws_last_q   <= ws_last_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      stage_q     <= stage_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      locked_q    <= locked_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign locked    = locked_q;

endmodule
